// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one BRAM controller user port among NUM_REQ requesters.
// Reads are tagged with the requester index and the returned data is routed back to it.
module bram_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DAT_WIDTH-1:0]  req_wdat,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DAT_WIDTH-1:0]          rdat,
  output logic [NUM_REQ-1:0]            rval,
  output logic                          err,
  output logic [ADDR_WIDTH-1:0]         ctl_addr,
  output logic                          ctl_wren,
  output logic [DAT_WIDTH-1:0]          ctl_idat,
  output logic                          ctl_rden,
  input  logic [DAT_WIDTH-1:0]          ctl_odat,
  input  logic                          ctl_oval
);

  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [ADDR_WIDTH-1:0] r_ctl_addr;
  logic [DAT_WIDTH-1:0]  r_ctl_idat;
  logic                  r_ctl_wren;
  logic                  r_ctl_rden;
  logic [IDX_WIDTH-1:0]  r_iss_idx;
  logic [DAT_WIDTH-1:0]  r_rdat;
  logic [NUM_REQ-1:0]    r_rval;
  logic                  r_err;

  logic                  r_tag_vld [RD_LAT];
  logic [IDX_WIDTH-1:0]  r_tag_idx [RD_LAT];

  logic [IDX_WIDTH:0]    w_sum  [NUM_REQ];
  logic [IDX_WIDTH:0]    w_wrap [NUM_REQ];
  logic [IDX_WIDTH-1:0]  w_cand [NUM_REQ];
  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_WIDTH-1:0]  w_gnt_idx;
  logic                  w_any;

  // Candidate k in search order is (ptr + k) mod NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_sum[gi]  = {1'b0, r_ptr} + (IDX_WIDTH+1)'(gi);
      assign w_wrap[gi] = w_sum[gi] - (IDX_WIDTH+1)'(NUM_REQ);
      assign w_cand[gi] = (w_sum[gi] >= (IDX_WIDTH+1)'(NUM_REQ)) ?
                          w_wrap[gi][IDX_WIDTH-1:0] : w_sum[gi][IDX_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!w_any && req[w_cand[k]]) begin
          w_any            = 1'b1;
          w_gnt_idx        = w_cand[k];
          w_gnt[w_cand[k]] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_ctl_addr <= '0;
      r_ctl_idat <= '0;
      r_ctl_wren <= 1'b0;
      r_ctl_rden <= 1'b0;
      r_iss_idx  <= '0;
    end else if (w_any) begin
      r_ptr      <= (w_gnt_idx == IDX_WIDTH'(NUM_REQ-1)) ? '0 : w_gnt_idx + IDX_WIDTH'(1);
      r_ctl_addr <= req_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      r_ctl_idat <= req_wdat[w_gnt_idx*DAT_WIDTH +: DAT_WIDTH];
      r_ctl_wren <= req_wr[w_gnt_idx];
      r_ctl_rden <= ~req_wr[w_gnt_idx];
      r_iss_idx  <= w_gnt_idx;
    end else begin
      r_ctl_wren <= 1'b0;
      r_ctl_rden <= 1'b0;
    end
  end

  // Stage 0 loads one cycle after rden, so the head lines up with oval RD_LAT cycles later.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (rst) begin
          r_tag_vld[gi] <= 1'b0;
          r_tag_idx[gi] <= '0;
        end else begin
          if (gi == 0) begin
            r_tag_vld[gi] <= r_ctl_rden;
            r_tag_idx[gi] <= r_iss_idx;
          end else begin
            r_tag_vld[gi] <= r_tag_vld[(gi == 0) ? 0 : gi-1];
            r_tag_idx[gi] <= r_tag_idx[(gi == 0) ? 0 : gi-1];
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdat <= '0;
      r_rval <= '0;
      r_err  <= 1'b0;
    end else begin
      r_rval <= '0;
      if (ctl_oval) begin
        if (r_tag_vld[RD_LAT-1]) begin
          r_rdat <= ctl_odat;
          r_rval <= NUM_REQ'(1) << r_tag_idx[RD_LAT-1];
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign gnt      = w_gnt;
  assign rdat     = r_rdat;
  assign rval     = r_rval;
  assign err      = r_err;
  assign ctl_addr = r_ctl_addr;
  assign ctl_idat = r_ctl_idat;
  assign ctl_wren = r_ctl_wren;
  assign ctl_rden = r_ctl_rden;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: stimulus pushes expected read returns into a
// scoreboard queue, a monitor pops and compares them whenever rval is seen.
module tb_bram_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en;
  logic [N-1:0]      req, req_wr;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdat;
  logic [N-1:0]      gnt, rval;
  logic [DW-1:0]     rdat;
  logic              err;
  logic [AW-1:0]     ctl_addr;
  logic              ctl_wren, ctl_rden;
  logic [DW-1:0]     ctl_idat;
  logic [DW-1:0]     ctl_odat;
  logic              ctl_oval;
  logic              r_oval;
  logic              force_oval;

  bram_arbiter #(.NUM_REQ(N), .IDX_WIDTH(2), .DAT_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdat(req_wdat), .gnt(gnt), .rdat(rdat),
    .rval(rval), .err(err), .ctl_addr(ctl_addr), .ctl_wren(ctl_wren),
    .ctl_idat(ctl_idat), .ctl_rden(ctl_rden), .ctl_odat(ctl_odat),
    .ctl_oval(ctl_oval)
  );

  // Controller model with one cycle read latency; cleared by the same reset.
  logic [DW-1:0] mem [256];
  bit            mem_init_done;
  assign ctl_oval = r_oval | force_oval;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'hCAFEF00D;
      mem[8'h31] <= 32'h5555AAAA;
      mem[8'h40] <= 32'h11111111;
      mem[8'h41] <= 32'h22222222;
      mem[8'h42] <= 32'h33333333;
      mem[8'h43] <= 32'h44444444;
      mem_init_done <= 1'b1;
    end
    if (rst) begin
      r_oval <= 1'b0;
    end else begin
      r_oval <= ctl_rden;
      if (ctl_rden) ctl_odat <= mem[ctl_addr[7:0]];
      if (ctl_wren) mem[ctl_addr[7:0]] <= ctl_idat;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  logic [31:0] td [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  int          order [8] = '{3, 0, 1, 2, 3, 0, 1, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_rd(input int i, input logic [31:0] a);
    req_wr[i] = 1'b0;
    req_addr[i*AW +: AW] = a;
  endtask

  // Monitor: every rval must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rval !== '0) begin
        if (sb.size() == 0) begin
          check("unexpected_rval", 64'(rval), 64'h0);
        end else begin
          mon_e = sb.pop_front();
          check("rval", 64'(rval), 64'(1) << mon_e.idx);
          check("rdat", 64'(rdat), 64'(mon_e.dat));
          check("rval_latency", 64'(cyc), 64'(mon_e.cyc));
          $display("read return: req %0d data %08h cycle %0d", mon_e.idx, rdat, cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; req_wr = '0;
    req_addr = '0; req_wdat = '0; force_oval = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_rval", 64'(rval), 64'h0);
    check("rst_err", 64'(err), 64'h0);
    check("rst_rden", 64'(ctl_rden), 64'h0);
    check("rst_wren", 64'(ctl_wren), 64'h0);
    check("rst_addr", 64'(ctl_addr), 64'h0);
    @(negedge clk); rst = 1'b0; en = 1'b1;

    // Single read by requester 2
    @(negedge clk);
    set_rd(2, 32'h10); req = 4'b0100; #1;
    check("t1_gnt", 64'(gnt), 64'h4);
    sb.push_back('{idx: 2, dat: 32'hDEADBEEF, cyc: cyc + 3});
    @(negedge clk);
    req = '0; #1;
    check("t1_rden", 64'(ctl_rden), 64'h1);
    check("t1_addr", 64'(ctl_addr), 64'h10);
    check("t1_idle_gnt", 64'(gnt), 64'h0);
    repeat (4) @(negedge clk);

    // All four requesters reading back to back; ptr starts at 3
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      if (s == 0) begin
        for (int i = 0; i < N; i++) set_rd(i, 32'h40 + 32'(i));
        req = 4'b1111;
      end
      #1;
      check("t2_gnt", 64'(gnt), 64'(1) << order[s]);
      sb.push_back('{idx: order[s], dat: td[order[s]], cyc: cyc + 3});
    end
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);

    // Write by requester 1 followed by a read of the same address by requester 3
    @(negedge clk);
    req_wr = 4'b0010; req_addr[1*AW +: AW] = 32'h20; req_wdat[1*DW +: DW] = 32'h12345678;
    req = 4'b0010; #1;
    check("t3_wr_gnt", 64'(gnt), 64'h2);
    @(negedge clk);
    req_wr = '0; set_rd(3, 32'h20); req = 4'b1000; #1;
    check("t3_rd_gnt", 64'(gnt), 64'h8);
    check("t3_wren", 64'(ctl_wren), 64'h1);
    check("t3_wr_addr", 64'(ctl_addr), 64'h20);
    check("t3_wr_dat", 64'(ctl_idat), 64'h12345678);
    sb.push_back('{idx: 3, dat: 32'h12345678, cyc: cyc + 3});
    @(negedge clk);
    req = '0; #1;
    check("t3_wren_off", 64'(ctl_wren), 64'h0);
    check("t3_rden", 64'(ctl_rden), 64'h1);
    repeat (4) @(negedge clk);

    // Read by requester 0, then enable dropped for 5 cycles while requester 1 waits
    @(negedge clk);
    set_rd(0, 32'h30); set_rd(1, 32'h31); req = 4'b0001; #1;
    check("t4_gnt0", 64'(gnt), 64'h1);
    sb.push_back('{idx: 0, dat: 32'hCAFEF00D, cyc: cyc + 3});
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 0) begin
        en = 1'b0; req = 4'b0010;
      end
      #1;
      check("t4_gnt_dis", 64'(gnt), 64'h0);
    end
    @(negedge clk);
    en = 1'b1; #1;
    check("t4_gnt1", 64'(gnt), 64'h2);
    sb.push_back('{idx: 1, dat: 32'h5555AAAA, cyc: cyc + 3});
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);

    // Two reads in flight then reset: no returns, pointer back to 0
    @(negedge clk);
    set_rd(2, 32'h10); set_rd(3, 32'h40); req = 4'b0100; #1;
    check("t5_gnt2", 64'(gnt), 64'h4);
    @(negedge clk);
    req = 4'b1000; #1;
    check("t5_gnt3", 64'(gnt), 64'h8);
    @(negedge clk);
    req = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    check("t5_rden_cleared", 64'(ctl_rden), 64'h0);
    @(negedge clk);
    set_rd(1, 32'h31); set_rd(3, 32'h43); req = 4'b1010; #1;
    check("t5_gnt_after_rst", 64'(gnt), 64'h2);
    sb.push_back('{idx: 1, dat: 32'h5555AAAA, cyc: cyc + 3});
    @(negedge clk); req = '0;
    repeat (5) @(negedge clk);
    #1;
    check("t5_err", 64'(err), 64'h0);

    // Spurious oval with nothing in flight
    @(negedge clk);
    force_oval = 1'b1;
    @(negedge clk);
    force_oval = 1'b0; #1;
    check("t6_err_set", 64'(err), 64'h1);
    repeat (3) @(negedge clk);
    #1;
    check("t6_err_sticky", 64'(err), 64'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("t6_err_cleared", 64'(err), 64'h0);
    repeat (2) @(negedge clk);
    #1;
    check("pending_returns", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
